// File: rtl/cdc_fifo_pkg.sv
// Shared types and helpers for the CDC FIFO write-side arbiter.
package cdc_fifo_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  // Grant index width; keeps one bit even for a degenerate single requester.
  function automatic int unsigned grant_id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdc_fifo_write_arbiter_if.sv
// Requester and FIFO write-side bundle for the write arbiter.
interface cdc_fifo_write_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  import cdc_fifo_pkg::*;

  localparam int unsigned GW = grant_id_width(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic [DATA_WIDTH-1:0]         fifo_write_data;
  logic                          fifo_increment;
  logic                          grant_valid;
  logic [GW-1:0]                 grant_id;

  modport master (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_write_data, fifo_increment, grant_valid, grant_id
  );

  modport slave (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_write_data, fifo_increment, grant_valid, grant_id
  );

endinterface

// File: rtl/rr_priority_select.sv
// Picks the first set request at or above ptr_i, wrapping modulo N.
module rr_priority_select #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          found_o,
  output logic [PW-1:0] idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = ptr_i;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned cand;
      cand = 32'(ptr_i) + i;
      if (cand >= N) cand = cand - N;
      if (!found_o && req_i[PW'(cand)]) begin
        found_o = 1'b1;
        idx_o   = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/cdc_fifo_write_arbiter.sv
// Round-robin, burst-locking arbiter sharing the CDC FIFO write port.
module cdc_fifo_write_arbiter
  import cdc_fifo_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input logic                     clock,
  input logic                     reset,
  cdc_fifo_write_arbiter_if.master bus
);

  localparam int unsigned GW = grant_id_width(NUM_REQ);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] S_IDLE  = ARB_IDLE;
  localparam logic [0:0] S_BURST = ARB_BURST;

  logic [0:0]    state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic          grant_valid_q, grant_valid_d;

  logic                  sel_found;
  logic [GW-1:0]         sel_idx;
  logic                  beat;
  logic [NUM_REQ-1:0]    ready_c;
  logic                  inc_c;
  logic [DATA_WIDTH-1:0] wdata_c;

  rr_priority_select #(
    .N  (NUM_REQ),
    .PW (GW)
  ) u_sel (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      beat_cnt_q    <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  // Sequencing plus the write-side strobes, which must follow fifo_full in the same cycle.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    ready_c       = '0;
    inc_c         = 1'b0;
    wdata_c       = '0;
    beat          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          grant_id_d    = sel_idx;
          grant_valid_d = 1'b1;
          state_d       = S_BURST;
        end
      end
      S_BURST: begin
        ready_c[grant_id_q] = !bus.fifo_full;
        wdata_c = bus.req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
        beat    = bus.req_valid[grant_id_q] & !bus.fifo_full;
        inc_c   = beat;
        if (beat) begin
          if (bus.req_last[grant_id_q] || (32'(beat_cnt_q) + 1 == MAX_BURST)) begin
            state_d       = S_IDLE;
            beat_cnt_d    = '0;
            grant_valid_d = 1'b0;
            if (32'(grant_id_q) == NUM_REQ - 1) rr_ptr_d = '0;
            else rr_ptr_d = grant_id_q + GW'(1);
          end else begin
            beat_cnt_d = beat_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready       = ready_c;
  assign bus.fifo_increment  = inc_c;
  assign bus.fifo_write_data = wdata_c;
  assign bus.grant_valid     = grant_valid_q;
  assign bus.grant_id        = grant_id_q;

endmodule

// File: tb/tb_cdc_fifo_write_arbiter.sv
// Directed bench for cdc_fifo_write_arbiter with hand-computed expectations.
module tb_cdc_fifo_write_arbiter;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  cdc_fifo_write_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

  cdc_fifo_write_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .MAX_BURST  (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic setd(input int idx, input logic [7:0] v);
    bus.req_data[idx*8 +: 8] = v;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gv"},    32'(bus.grant_valid),    32'h0);
    chk({tag, "_inc"},   32'(bus.fifo_increment), 32'h0);
    chk({tag, "_rdy"},   32'(bus.req_ready),      32'h0);
    chk({tag, "_wdata"}, 32'(bus.fifo_write_data), 32'h0);
  endtask

  task automatic chk_beat(input string tag, input int id, input logic [7:0] d);
    chk({tag, "_gv"},    32'(bus.grant_valid),    32'h1);
    chk({tag, "_gid"},   32'(bus.grant_id),       32'(id));
    chk({tag, "_inc"},   32'(bus.fifo_increment), 32'h1);
    chk({tag, "_wdata"}, 32'(bus.fifo_write_data), 32'(d));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;

    #12;
    chk_idle("reset");
    chk("reset_gid", 32'(bus.grant_id), 32'h0);
    #10 reset = 1'b0;

    // Single requester 2: three beats, then rr_pointer must sit at 3.
    step(); bus.req_valid = 4'b0100; setd(2, 8'h11); #1;
    chk_idle("s_decide");
    step(); #1;
    chk_beat("s_b0", 2, 8'h11);
    chk("s_b0_rdy", 32'(bus.req_ready), 32'h4);
    step(); setd(2, 8'h22); #1;
    chk_beat("s_b1", 2, 8'h22);
    step(); setd(2, 8'h33); bus.req_last = 4'b0100; #1;
    chk_beat("s_b2", 2, 8'h33);
    step(); bus.req_valid = 4'b1001; bus.req_last = 4'b1001; setd(3, 8'h3C); setd(0, 8'h0C); #1;
    chk_idle("s_end");
    step(); #1;
    chk_beat("s_ptr3", 3, 8'h3C);
    chk("s_ptr3_rdy", 32'(bus.req_ready), 32'h8);
    step(); #1;
    chk_idle("s_wrap_decide");
    step(); #1;
    chk_beat("s_wrap0", 0, 8'h0C);
    step(); bus.req_valid = '0; bus.req_last = '0; #1;
    chk_idle("s_done");

    // Burst cap: requester 1 streams six words, no last.
    step(); bus.req_valid = 4'b0010; setd(1, 8'h51); #1;
    chk_idle("cap_decide");
    for (int k = 0; k < 4; k++) begin
      step(); setd(1, 8'(8'h51 + k)); #1;
      chk_beat("cap_beat", 1, 8'(8'h51 + k));
    end
    step(); setd(1, 8'h55); #1;
    chk_idle("cap_gap");
    step(); #1;
    chk_beat("cap_re0", 1, 8'h55);
    step(); setd(1, 8'h56); bus.req_last = 4'b0010; #1;
    chk_beat("cap_re1", 1, 8'h56);
    step(); bus.req_valid = '0; bus.req_last = '0; #1;
    chk_idle("cap_done");

    // Full backpressure on requester 0 after one beat.
    step(); bus.req_valid = 4'b0001; setd(0, 8'h70); #1;
    chk_idle("full_decide");
    step(); #1;
    chk_beat("full_b0", 0, 8'h70);
    for (int k = 0; k < 3; k++) begin
      step(); bus.fifo_full = 1'b1; setd(0, 8'h71); #1;
      chk("full_gv",  32'(bus.grant_valid),    32'h1);
      chk("full_rdy", 32'(bus.req_ready),      32'h0);
      chk("full_inc", 32'(bus.fifo_increment), 32'h0);
    end
    step(); bus.fifo_full = 1'b0; #1;
    chk_beat("full_b1", 0, 8'h71);
    chk("full_b1_rdy", 32'(bus.req_ready), 32'h1);
    step(); setd(0, 8'h72); #1;
    chk_beat("full_b2", 0, 8'h72);
    step(); setd(0, 8'h73); #1;
    chk_beat("full_b3", 0, 8'h73);
    step(); bus.req_valid = '0; #1;
    chk_idle("full_done");

    // Reset mid-burst on requester 3, then fairness from a clean pointer.
    step(); bus.req_valid = 4'b1000; setd(3, 8'hD0); #1;
    chk_idle("rst_decide");
    step(); #1;
    chk_beat("rst_b0", 3, 8'hD0);
    step(); setd(3, 8'hD1); #1;
    chk_beat("rst_b1", 3, 8'hD1);
    #1 reset = 1'b1;
    #1;
    chk_idle("rst_async");
    chk("rst_async_gid", 32'(bus.grant_id), 32'h0);
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    for (int j = 0; j < 4; j++) setd(j, 8'(8'hF0 + j));
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(); #1;
      chk_beat("rr_grant", i % 4, 8'(8'hF0 + (i % 4)));
      step();
      if (i == 5) begin
        bus.req_valid = '0;
        bus.req_last  = '0;
      end
      #1;
      chk_idle("rr_idle");
    end

    // Valid gap inside a burst by requester 2 while requester 0 waits.
    step(); bus.req_valid = 4'b0101; setd(2, 8'hA0); setd(0, 8'h0E); #1;
    chk_idle("gap_decide");
    step(); #1;
    chk_beat("gap_b0", 2, 8'hA0);
    for (int k = 0; k < 2; k++) begin
      step(); bus.req_valid = 4'b0001; #1;
      chk("gap_gv",  32'(bus.grant_valid),    32'h1);
      chk("gap_gid", 32'(bus.grant_id),       32'h2);
      chk("gap_inc", 32'(bus.fifo_increment), 32'h0);
      chk("gap_rdy", 32'(bus.req_ready),      32'h4);
    end
    step(); bus.req_valid = 4'b0101; bus.req_last = 4'b0100; setd(2, 8'hA1); #1;
    chk_beat("gap_b1", 2, 8'hA1);
    step(); bus.req_valid = 4'b0001; bus.req_last = 4'b0001; #1;
    chk_idle("gap_end");
    step(); #1;
    chk_beat("gap_next0", 0, 8'h0E);
    step(); bus.req_valid = '0; bus.req_last = '0; #1;
    chk_idle("gap_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
